pocket_i2s_rx: RTL

POCKET_I2S_RX -- requirements
Module: pocket_i2s_rx

---
 rtl/pocket_i2s_rx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pocket_i2s_rx.sv
// I2S receiver: synchronizes sclk/lrck/data into clk_sys, assembles 16-bit
// stereo samples, and tracks frame integrity and lock.
module pocket_i2s_rx #(
  parameter int unsigned STALL_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        audio_sclk,
  input  logic        audio_lrck,
  input  logic        audio_dac,
  output logic [15:0] audio_l,
  output logic [15:0] audio_r,
  output logic        sample_valid,
  output logic        frame_err,
  output logic        locked
);

  localparam int SW = $clog2(STALL_CYCLES + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYCLES);

  logic [2:0]    sclk_r;
  logic [1:0]    lrck_r;
  logic [1:0]    dac_r;
  logic          prev_lrck_r;
  logic          started_r;
  logic          seen_r;
  logic [5:0]    cnt_r;
  logic [15:0]   shift_r;
  logic [15:0]   hold_l_r;
  logic          left_ok_r;
  logic [1:0]    good_r;
  logic [SW-1:0] stall_r;

  logic sclk_evt_s;
  logic boundary_s;
  logic len_ok_s;
  logic stalled_s;

  // The very first event after reset only learns lrck, so a mid-word release
  // never looks like a real channel boundary.
  assign sclk_evt_s = sclk_r[1] & ~sclk_r[2];
  assign boundary_s = sclk_evt_s & started_r & (lrck_r[1] != prev_lrck_r);
  assign len_ok_s   = (cnt_r >= 6'd16);
  assign stalled_s  = (stall_r == STALL_MAX);

  // Synchronizers, framing state machine and registered outputs.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sclk_r       <= 3'b000;
      lrck_r       <= 2'b00;
      dac_r        <= 2'b00;
      prev_lrck_r  <= 1'b0;
      started_r    <= 1'b0;
      seen_r       <= 1'b0;
      cnt_r        <= 6'd0;
      shift_r      <= 16'h0000;
      hold_l_r     <= 16'h0000;
      left_ok_r    <= 1'b0;
      good_r       <= 2'd0;
      stall_r      <= '0;
      audio_l      <= 16'h0000;
      audio_r      <= 16'h0000;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      sclk_r       <= {sclk_r[1:0], audio_sclk};
      lrck_r       <= {lrck_r[0], audio_lrck};
      dac_r        <= {dac_r[0], audio_dac};
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;

      if (sclk_evt_s) begin
        stall_r <= '0;
      end else if (!stalled_s) begin
        stall_r <= stall_r + 1'b1;
      end

      if (stalled_s) begin
        locked    <= 1'b0;
        left_ok_r <= 1'b0;
        good_r    <= 2'd0;
        seen_r    <= 1'b0;
      end

      if (sclk_evt_s) begin
        started_r   <= 1'b1;
        prev_lrck_r <= lrck_r[1];
        if (boundary_s) begin
          cnt_r  <= 6'd0;
          seen_r <= 1'b1;
          // The half preceding the first boundary is partial: skip it entirely.
          if (seen_r) begin
            if (len_ok_s) begin
              if (prev_lrck_r) begin
                hold_l_r  <= shift_r;
                left_ok_r <= 1'b1;
              end else begin
                if (left_ok_r) begin
                  audio_l      <= hold_l_r;
                  audio_r      <= shift_r;
                  sample_valid <= 1'b1;
                  if (good_r != 2'd2) good_r <= good_r + 2'd1;
                  if (good_r != 2'd0) locked <= 1'b1;
                end
                left_ok_r <= 1'b0;
              end
            end else begin
              left_ok_r <= 1'b0;
              frame_err <= 1'b1;
              good_r    <= 2'd0;
              locked    <= 1'b0;
            end
          end
        end else begin
          if (cnt_r != 6'd63) cnt_r <= cnt_r + 6'd1;
          // This event's count is cnt_r+1; bits 1..16 carry the word.
          if (cnt_r < 6'd16) shift_r <= {shift_r[14:0], dac_r[1]};
        end
      end
    end
  end

endmodule
